// File: rtl/demux1to5_scroll_if.sv
// Slot-write and scroll bundle between the character source
// and the five-slot registered demultiplexer.
interface demux1to5_scroll_if;
  logic       Clear;
  logic       Wr;
  logic [2:0] Sel;
  logic [2:0] In;
  logic       ScrollEn;
  logic [2:0] outU;
  logic [2:0] outV;
  logic [2:0] outW;
  logic [2:0] outX;
  logic [2:0] outY;
  logic       Ack;
  logic       Err;
  logic       Tick;

  modport master (
    output Clear, Wr, Sel, In, ScrollEn,
    input  outU, outV, outW, outX, outY,
    input  Ack, Err, Tick
  );

  modport slave (
    input  Clear, Wr, Sel, In, ScrollEn,
    output outU, outV, outW, outX, outY,
    output Ack, Err, Tick
  );
endinterface

// File: rtl/demux1to5_scroll.sv
// Registered 1-to-5 character demux with optional left scroll
// of all five slots at a prescaled rate.
module demux1to5_scroll #(
  parameter int         DIV   = 50000000,
  parameter int         CW    = 26,
  parameter logic [2:0] BLANK = 3'b111
) (
  input logic                 Clock,
  input logic                 Reset,
  demux1to5_scroll_if.slave   bus
);

  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [2:0]    slot_q [5];
  logic [2:0]    slot_d [5];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rot;
  logic          legal;
  logic          wr_ok;
  logic          wr_bad;
  logic          ack_q;
  logic          err_q;
  logic          tick_q;

  assign rot    = bus.ScrollEn && (cnt_q == TC);
  assign legal  = bus.Sel < 3'd5;
  assign wr_ok  = bus.Wr && legal && !bus.Clear;
  assign wr_bad = bus.Wr && !legal && !bus.Clear;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (bus.Clear || !bus.ScrollEn || rot)
      cnt_d = '0;
  end

  // Rotate first, then let a write land in the rotated image.
  always_comb begin
    for (int i = 0; i < 5; i++)
      slot_d[i] = slot_q[i];
    if (rot)
      for (int i = 0; i < 5; i++)
        slot_d[i] = slot_q[(i + 1) % 5];
    for (int i = 0; i < 5; i++)
      if (wr_ok && bus.Sel == 3'(i))
        slot_d[i] = bus.In;
    if (bus.Clear)
      for (int i = 0; i < 5; i++)
        slot_d[i] = BLANK;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++)
        slot_q[i] <= BLANK;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++)
        slot_q[i] <= slot_d[i];
      cnt_q  <= cnt_d;
      ack_q  <= wr_ok;
      err_q  <= wr_bad;
      tick_q <= rot && !bus.Clear;
    end
  end

  assign bus.outU = slot_q[0];
  assign bus.outV = slot_q[1];
  assign bus.outW = slot_q[2];
  assign bus.outX = slot_q[3];
  assign bus.outY = slot_q[4];
  assign bus.Ack  = ack_q;
  assign bus.Err  = err_q;
  assign bus.Tick = tick_q;

endmodule

// File: tb/tb_demux1to5_scroll.sv
// Vector table plus scoreboard bench for demux1to5_scroll,
// with hand sequences for async reset and count restart.
module tb_demux1to5_scroll;

  localparam int DIV = 4;
  localparam int CW  = 2;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [2:0]  sel;
    logic [2:0]  din;
    logic        sc;
    logic [14:0] slots;
    logic        ack;
    logic        err;
    logic        tick;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];
  vec_t        sb[$];
  logic [14:0] got;

  always #5 clk = ~clk;

  demux1to5_scroll_if bus ();

  demux1to5_scroll #(
    .DIV(DIV), .CW(CW), .BLANK(3'b111)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  assign got = {bus.outU, bus.outV, bus.outW, bus.outX, bus.outY};

  function automatic vec_t mk(
    logic c, logic w, logic [2:0] s, logic [2:0] d, logic e,
    logic [14:0] sl, logic a, logic r, logic t);
    vec_t v;
    v.clr = c; v.wr = w; v.sel = s; v.din = d; v.sc = e;
    v.slots = sl; v.ack = a; v.err = r; v.tick = t;
    return v;
  endfunction

  task automatic check(string nm, logic [14:0] es,
                       logic ea, logic ee, logic et);
    checks++;
    if ({got, bus.Ack, bus.Err, bus.Tick} !== {es, ea, ee, et}) begin
      errors++;
      $display("FAIL %s: got slots=%o a/e/t=%b%b%b want slots=%o a/e/t=%b%b%b",
               nm, got, bus.Ack, bus.Err, bus.Tick, es, ea, ee, et);
    end
  endtask

  task automatic drive(vec_t v);
    bus.Clear = v.clr; bus.Wr = v.wr; bus.Sel = v.sel;
    bus.In = v.din; bus.ScrollEn = v.sc;
  endtask

  task automatic step(string nm, vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(nm, e.slots, e.ack, e.err, e.tick);
  endtask

  initial begin
    int n;
    // load message, illegal selects, Wr=0
    tbl.push_back(mk(0,1,0,0,0, 15'o07777,1,0,0));
    tbl.push_back(mk(0,1,1,1,0, 15'o01777,1,0,0));
    tbl.push_back(mk(0,1,2,2,0, 15'o01277,1,0,0));
    tbl.push_back(mk(0,1,3,2,0, 15'o01227,1,0,0));
    tbl.push_back(mk(0,1,4,3,0, 15'o01223,1,0,0));
    tbl.push_back(mk(0,1,5,4,0, 15'o01223,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 15'o01223,0,0,0));
    tbl.push_back(mk(0,1,7,1,0, 15'o01223,0,1,0));
    tbl.push_back(mk(0,0,0,5,0, 15'o01223,0,0,0));
    // scroll, tick every 4th cycle
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o12230,0,0,1));
    tbl.push_back(mk(0,0,0,0,1, 15'o12230,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o12230,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o12230,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,1));
    // two counts, drop ScrollEn, restart
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o22301,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o23012,0,0,1));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(0,0,0,0,1, k ? 15'o30122 : 15'o23012,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, k ? 15'o30122 : 15'o23012,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, k ? 15'o30122 : 15'o23012,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, k ? 15'o01223 : 15'o30122,0,0,1));
    end
    // collision: rotate then write Y
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o01223,0,0,0));
    tbl.push_back(mk(0,1,4,6,1, 15'o12236,1,0,1));
    // clear beats write, then clear beats rotation
    tbl.push_back(mk(1,1,0,2,0, 15'o77777,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 15'o77777,0,0,0));
    tbl.push_back(mk(0,1,0,1,1, 15'o17777,1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o17777,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o17777,0,0,0));
    tbl.push_back(mk(1,0,0,0,1, 15'o77777,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o77777,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o77777,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o77777,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 15'o77777,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 15'o77777,0,0,0));

    drive(mk(0,0,0,0,0, 15'o0,0,0,0));
    #2 rst = 1'b1;
    #1 check("reset_async", 15'o77777, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      step($sformatf("idle%0d", i), mk(0,0,0,0,0, 15'o77777,0,0,0));

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i]);

    // async reset two counts into a scroll period
    step("pre_wr", mk(0,1,0,5,0, 15'o57777,1,0,0));
    step("pre_c1", mk(0,0,0,0,1, 15'o57777,0,0,0));
    step("pre_c2", mk(0,1,1,4,1, 15'o54777,1,0,0));
    #2 rst = 1'b1;
    #1 check("reset_mid", 15'o77777, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0,0,1, 15'o0,0,0,0));
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.Tick === 1'b1) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != DIV) begin
      errors++;
      $display("FAIL tick_after_reset: got %0d cycles want %0d", n, DIV);
    end
    check("tick_blank", 15'o77777, 0, 0, 1);
    step("tick_drop", mk(0,0,0,0,0, 15'o77777,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
